// File: rtl/register_load_unit.sv
// LITE-16 register load unit: memory read over req/ack, one-hot regfile write,
// per-register pending scoreboard and wait timeout.
module register_load_unit #(
   parameter int WIDTH    = 16,
   parameter int REGS     = 16,
   parameter int WAIT_MAX = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       dst,
   input  logic [WIDTH-1:0] addr,
   output logic             busy,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_data,
   output logic [REGS-1:0]  wr_en,
   output logic [WIDTH-1:0] wr_data,
   output logic [REGS-1:0]  pending,
   output logic             err
);

   localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST =
      (WAIT_MAX > 0) ? CW'(WAIT_MAX - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_WRITE
   } state_t;

   state_t           state_q, state_n;
   logic [3:0]       dst_q, dst_n;
   logic [WIDTH-1:0] addr_q, addr_n;
   logic [WIDTH-1:0] data_q, data_n;
   logic [CW-1:0]    cnt_q, cnt_n;
   logic [REGS-1:0]  pend_q, pend_n;
   logic             err_q, err_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dst_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         pend_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         dst_q   <= dst_n;
         addr_q  <= addr_n;
         data_q  <= data_n;
         cnt_q   <= cnt_n;
         pend_q  <= pend_n;
         err_q   <= err_n;
      end
   end

   always_comb begin
      state_n = state_q;
      dst_n   = dst_q;
      addr_n  = addr_q;
      data_n  = data_q;
      cnt_n   = cnt_q;
      pend_n  = pend_q;
      err_n   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_n = ST_WAIT;
               dst_n   = dst;
               addr_n  = addr;
               cnt_n   = '0;
               pend_n  = REGS'(1) << dst;
            end
         end
         ST_WAIT: begin
            // ack takes priority over a timeout on the same edge
            if (mem_ack) begin
               state_n = ST_WRITE;
               data_n  = mem_data;
            end else if (WAIT_MAX > 0 && cnt_q == CNT_LAST) begin
               state_n        = ST_IDLE;
               pend_n[dst_q]  = 1'b0;
               err_n          = 1'b1;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
         ST_WRITE: begin
            state_n       = ST_IDLE;
            pend_n[dst_q] = 1'b0;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign busy     = (state_q != ST_IDLE);
   assign mem_req  = (state_q == ST_WAIT);
   assign mem_addr = addr_q;
   assign wr_en    = (state_q == ST_WRITE) ? (REGS'(1) << dst_q) : '0;
   assign wr_data  = data_q;
   assign pending  = pend_q;
   assign err      = err_q;

endmodule

// File: tb/tb_register_load_unit.sv
// Bench for register_load_unit: directed loads plus random loads checked
// against a per-transaction timing model and a register-file model.
module tb_register_load_unit;

   localparam int WAIT_MAX = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  dst = '0;
   logic [15:0] addr = '0;
   logic        busy;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_data = '0;
   logic [15:0] wr_en;
   logic [15:0] wr_data;
   logic [15:0] pending;
   logic        err;

   int total = 0;
   int bad = 0;

   logic [15:0] rf_dut [16];
   logic [15:0] rf_exp [16];

   register_load_unit #(
      .WIDTH(16),
      .REGS(16),
      .WAIT_MAX(WAIT_MAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dst(dst),
      .addr(addr),
      .busy(busy),
      .mem_req(mem_req),
      .mem_addr(mem_addr),
      .mem_ack(mem_ack),
      .mem_data(mem_data),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .pending(pending),
      .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 16; i++) rf_dut[i] = '0;
   end

   always @(posedge clk) begin
      for (int i = 0; i < 16; i++)
         if (wr_en[i]) rf_dut[i] <= wr_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input logic exp_err);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_req"}, 32'(mem_req), 0);
      chk({tag, "_wr"}, 32'(wr_en), 0);
      chk({tag, "_pend"}, 32'(pending), 0);
      chk({tag, "_err"}, 32'(err), 32'(exp_err));
   endtask

   // delay = WAIT cycles without ack before the ack cycle;
   // delay >= WAIT_MAX means the memory never answers
   task automatic run_load(input logic [3:0] d, input logic [15:0] a,
                           input logic [15:0] v, input int delay,
                           input bit inj);
      bit to;
      int waits;
      to = (delay >= WAIT_MAX);
      waits = to ? WAIT_MAX : delay + 1;
      start = 1'b1;
      dst = d;
      addr = a;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      dst = 4'($urandom);
      addr = 16'($urandom);
      for (int i = 0; i < waits; i++) begin
         chk("w_busy", 32'(busy), 1);
         chk("w_req", 32'(mem_req), 1);
         chk("w_addr", 32'(mem_addr), 32'(a));
         chk("w_pend", 32'(pending), 32'(1) << d);
         chk("w_wr", 32'(wr_en), 0);
         chk("w_err", 32'(err), 0);
         if (inj && i == 1) begin
            start = 1'b1;
            dst = d + 4'd1;
            addr = 16'h1111;
         end else begin
            start = 1'b0;
         end
         mem_ack = !to && (i == delay);
         mem_data = mem_ack ? v : 16'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      mem_ack = 1'b0;
      start = 1'b0;
      if (!to) begin
         chk("wr_en", 32'(wr_en), 32'(1) << d);
         chk("wr_data", 32'(wr_data), 32'(v));
         chk("wr_pend", 32'(pending), 32'(1) << d);
         chk("wr_req", 32'(mem_req), 0);
         chk("wr_err", 32'(err), 0);
         rf_exp[d] = v;
      end else begin
         chk_idle("to", 1'b1);
      end
      @(posedge clk);
      @(negedge clk);
      chk_idle("end", 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) rf_exp[i] = '0;
      #2;
      chk_idle("rst", 1'b0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_data", 32'(wr_data), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_load(4'd3, 16'h0040, 16'h0123, 0, 1'b0);
      run_load(4'd15, 16'h1234, 16'hAEAE, 5, 1'b0);
      run_load(4'd7, 16'h0777, 16'h5555, WAIT_MAX, 1'b0);
      run_load(4'd1, 16'h0101, 16'hB1B1, 4, 1'b1);
      run_load(4'd9, 16'h0909, 16'h9C9C, WAIT_MAX - 1, 1'b0);
      run_load(4'd4, 16'h0444, 16'h4444, 0, 1'b0);
      run_load(4'd5, 16'h0555, 16'h5A5A, 0, 1'b0);

      // reset in the middle of WAIT, then a stale ack
      start = 1'b1;
      dst = 4'd6;
      addr = 16'h0666;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_req", 32'(mem_req), 1);
      rst = 1'b1;
      #1;
      chk_idle("arst", 1'b0);
      chk("arst_addr", 32'(mem_addr), 0);
      @(negedge clk);
      rst = 1'b0;
      mem_ack = 1'b1;
      mem_data = 16'h4545;
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      chk_idle("late", 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk_idle("late2", 1'b0);

      for (int n = 0; n < 24; n++) begin
         run_load(4'($urandom), 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, WAIT_MAX + 2)),
                  bit'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 16; i++)
         chk($sformatf("rf%0d", i), 32'(rf_dut[i]), 32'(rf_exp[i]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/register_load_unit.md
# register_load_unit

Sequential load unit for the LITE-16 register path. It accepts a load command (destination register, memory address), runs a request/acknowledge read on the data-memory port, and writes the returned word into the 16×16 register file through its one-hot write port. This is the write-side partner of the register fetch unit. A per-register pending scoreboard lets fetch/decode stall on registers whose load has not completed.

## Interface
- WIDTH, 16: data and address width.
- REGS, 16: register count; one-hot write-enable width.
- WAIT_MAX, 15: maximum cycles in WAIT before the load is aborted; 0 disables the timeout.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  load command valid; sampled only when busy=0.
- dst  in  4  destination register index.
- addr  in  WIDTH  memory address.
- busy  out  1  high whenever state≠IDLE.
- mem_req  out  1  memory read request.
- mem_addr  out  WIDTH  address presented with mem_req.
- mem_ack  in  1  memory response valid.
- mem_data  in  WIDTH  read data, valid when mem_ack=1.
- wr_en  out  REGS  one-hot register-file write enable.
- wr_data  out  WIDTH  register-file write data.
- pending  out  REGS  bit i high while a load to register i is outstanding.
- err  out  1  one-cycle pulse on timeout abort.

## Operation
- FSM states: IDLE, WAIT, WRITE.
- IDLE:
  - start=1 at an edge → latch dst and addr, set pending[dst], go to WAIT.
  - start=0 → stay in IDLE.
- WAIT:
  - mem_req=1 and mem_addr=latched addr, held stable until mem_ack is sampled high.
  - mem_ack=1 at an edge → latch mem_data, go to WRITE.
  - Timeout counter clears on entry and increments each WAIT cycle without ack. When it reaches WAIT_MAX (WAIT_MAX>0) without ack → go to IDLE, clear pending[dst], pulse err, no register write.
  - If ack and timeout occur on the same edge, ack wins.
- WRITE: for exactly one cycle, wr_en = 1<<dst and wr_data = latched data. At the end of the cycle, clear pending[dst] and go to IDLE.
- mem_req=0 in IDLE and WRITE. wr_en=0 outside WRITE.
- start while busy=1 is ignored: no latch, no scoreboard change. The issuer must hold or retry.
- Only one load is outstanding at a time, so at most one pending bit is set.
- mem_ack while not in WAIT is ignored.

## Timing
- Reset values: state=IDLE, busy=0, mem_req=0, mem_addr=0, wr_en=0, wr_data=0, pending=0, err=0, counter=0.
- Asserting rst mid-operation aborts immediately with no write and no err pulse. A late mem_ack after reset release is ignored.
- Minimum latency, with start sampled at edge E:
  - mem_req high in cycle E..E+1.
  - With an immediate ack sampled at E+1, wr_en is high in cycle E+1..E+2 and the register file captures at E+2.
  - busy falls after E+2, so a new start can be accepted at edge E+3.
- General case: the write occurs 1 cycle after the ack edge.
- pending[dst] is high from edge E through the edge that performs the register write, inclusive.
- Timeout: with no ack, mem_req stays high for WAIT_MAX cycles. err is high for the single cycle following the abort edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Basic load:
  - Stimulus: start, dst=3, addr=0x0040; memory acks 0x0123 on the first req cycle.
  - Required response: mem_addr=0x0040; wr_en=0x0008 with wr_data=0x0123 for exactly one cycle, 2 edges after acceptance; pending[3] high then cleared.
- Delayed ack:
  - Stimulus: dst=15, ack with data 0xAEAE after 5 wait cycles.
  - Required response: mem_req held 6 cycles; wr_en=0x8000 with 0xAEAE for one cycle; err never asserts.
- Timeout:
  - Stimulus: dst=7, WAIT_MAX=15, no ack.
  - Required response: mem_req drops after 15 cycles; err pulses once; wr_en stays 0; pending[7] clears; busy falls.
- Start while busy:
  - Stimulus: a second start (dst=2, addr=0x1111) during WAIT of a load to dst=1.
  - Required response: ignored; only wr_en=0x0002 is written, with the first load's data; pending[2] never set.
- Reset mid-operation:
  - Stimulus: assert rst during WAIT, then ack 0x4545 after release.
  - Required response: all outputs go to reset values asynchronously; no write occurs.
- Back-to-back:
  - Stimulus: two loads, dst=4 then dst=5, the second start asserted the cycle busy falls.
  - Required response: both written in order; the second accepted at the earliest permitted edge.
